mod_mul: RTL and testbench

- Sequential modular multiplier over the secp256k1 prime field. Computes product = (a · b) mod p by interleaved MSB-first double-and-add, one multiplier bit per cycle.
- Sits beside mod_inv in the field-arithmetic layer of the point pipeline. It consumes mod_inv's inverse output, for example multiplying by Z⁻¹ during Jacobian-to-affine conversion.
- Uses the same start/done handshake as mod_inv.

---
 rtl/secp256k1_pkg.sv | 19 +
 rtl/mod_add_red.sv | 18 +
 rtl/mod_mul.sv | 110 +++++++++++
 tb/tb_mod_mul.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/secp256k1_pkg.sv
// rtl/secp256k1_pkg.sv - shared constants and types for the secp256k1 field-arithmetic layer
package secp256k1_pkg;

    localparam int FIELD_W = 256;

    localparam logic [FIELD_W-1:0] P =
        256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;

    // 2^256 - p, useful for reduction tricks in neighbouring blocks
    localparam logic [FIELD_W-1:0] P_COMPL = 256'h1000003D1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } mm_state_t;

endpackage

// File: rtl/mod_add_red.sv
// rtl/mod_add_red.sv - combinational (x + y) mod p for x, y < p
module mod_add_red
    import secp256k1_pkg::*;
(
    input  logic [FIELD_W-1:0] x,
    input  logic [FIELD_W-1:0] y,
    output logic [FIELD_W-1:0] sum
);

    logic [FIELD_W:0] w_sum;
    logic [FIELD_W:0] w_red;

    // x + y < 2p, so a single conditional subtraction fully reduces
    assign w_sum = {1'b0, x} + {1'b0, y};
    assign w_red = w_sum - {1'b0, P};
    assign sum   = (w_sum >= {1'b0, P}) ? w_red[FIELD_W-1:0] : w_sum[FIELD_W-1:0];

endmodule

// File: rtl/mod_mul.sv
// rtl/mod_mul.sv - sequential (a * b) mod p, MSB-first double-and-add, one bit per cycle
module mod_mul
    import secp256k1_pkg::*;
#(
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] product,
    output logic             done,
    output logic             busy
);

    mm_state_t        r_state;
    mm_state_t        w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [7:0]       r_cnt;
    logic [WIDTH-1:0] r_product;
    logic [WIDTH-1:0] w_dbl;
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_acc_next;

    mod_add_red u_double (
        .x   (r_acc),
        .y   (r_acc),
        .sum (w_dbl)
    );

    mod_add_red u_accum (
        .x   (w_dbl),
        .y   (w_addend),
        .sum (w_acc_next)
    );

    assign w_addend = r_b[r_cnt] ? r_a : '0;
    assign product  = r_product;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        done         = 1'b0;
        busy         = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next_state = LOAD;
                end
            end
            LOAD: w_next_state = RUN;
            RUN: begin
                if (r_cnt == 8'd0) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_cnt     <= 8'd0;
            r_product <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a <= a;
                        r_b <= b;
                    end
                end
                LOAD: begin
                    // 2^256 < 2p, so one subtraction brings any input below p
                    r_a   <= (r_a >= P) ? (r_a - P) : r_a;
                    r_acc <= '0;
                    r_cnt <= 8'd255;
                end
                RUN: begin
                    r_acc <= w_acc_next;
                    if (r_cnt == 8'd0) begin
                        r_product <= w_acc_next;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_mul.sv
// tb/tb_mod_mul.sv - self-checking bench for mod_mul against a wide-arithmetic reference
module tb_mod_mul;

    localparam logic [255:0] P_REF =
        256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
    localparam logic [255:0] INV2 =
        256'h7FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF7FFFFE18;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [255:0] a = '0;
    logic [255:0] b = '0;
    logic [255:0] product;
    logic         done;
    logic         busy;

    int n_checks = 0;
    int n_fail = 0;

    mod_mul #(.WIDTH(256)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .product (product),
        .done    (done),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] ref_mul(input logic [255:0] x, input logic [255:0] y);
        logic [511:0] t;
        logic [511:0] m;
        t = {256'b0, x} * {256'b0, y};
        m = t % {256'b0, P_REF};
        return m[255:0];
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = {r[223:0], $urandom()};
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // start in cycle 0, expect done in cycle 258 and busy low in cycle 259
    task automatic run_op(input logic [255:0] va, input logic [255:0] vb, input string name);
        int           lat;
        bit           seen;
        logic [255:0] expv;
        expv  = ref_mul(va, vb);
        a     = va;
        b     = vb;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = rand256();
        b     = rand256();
        lat   = 1;
        seen  = 1'b0;
        while (lat < 400 && !seen) begin
            if (done === 1'b1) seen = 1'b1;
            else begin
                tick();
                lat++;
            end
        end
        n_checks++;
        if (!seen || lat != 258) begin
            n_fail++;
            $display("FAIL %s latency: done seen=%0d at cycle %0d, want cycle 258", name, seen, lat);
        end
        n_checks++;
        if (product !== expv) begin
            n_fail++;
            $display("FAIL %s product: got %h want %h", name, product, expv);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle after done: busy=%b done=%b want 0 0", name, busy, done);
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_checks++;
        if (product !== 256'd0 || done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: product=%h done=%b busy=%b want 0 0 0", product, done, busy);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        run_op(256'd2, 256'd3, "two_times_three");
        run_op(P_REF - 256'd1, P_REF - 256'd1, "pm1_squared");
    endtask

    task automatic test_inverse();
        logic [255:0] inv;
        run_op(256'd2, INV2, "two_times_inv2");
        inv = (P_REF >> 1) + 256'd1;
        run_op(256'd2, inv, "two_times_derived_inv");
    endtask

    task automatic test_unreduced();
        run_op(P_REF + 256'd5, 256'd1, "a_p_plus_5");
        run_op(256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF,
               256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF, "all_ones");
    endtask

    task automatic test_zero();
        run_op(256'd0, rand256(), "a_zero");
        run_op(rand256(), 256'd0, "b_zero");
    endtask

    task automatic test_disturb();
        int pulses;
        a     = rand256();
        b     = rand256();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 102; c++) tick();
        reset = 1'b1;
        #1;
        n_checks++;
        if (product !== 256'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset: product=%h busy=%b done=%b want 0 0 0", product, busy, done);
        end
        tick();
        tick();
        reset  = 1'b0;
        pulses = 0;
        for (int c = 0; c < 300; c++) begin
            if (done === 1'b1) pulses++;
            tick();
        end
        n_checks++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL midrun_no_done: got %0d done pulses want 0", pulses);
        end
        run_op(256'd7, 256'd9, "after_reset_7x9");
    endtask

    task automatic test_back_to_back();
        int q[$];
        int wait_c;
        a     = 256'd3;
        b     = 256'd5;
        start = 1'b1;
        for (int c = 0; c < 600; c++) begin
            if (done === 1'b1) q.push_back(c);
            tick();
        end
        start  = 1'b0;
        wait_c = 0;
        while (busy !== 1'b0 && wait_c < 400) begin
            tick();
            wait_c++;
        end
        n_checks++;
        if (q.size() != 2) begin
            n_fail++;
            $display("FAIL held_start_pulse_count: got %0d want 2", q.size());
        end else begin
            n_checks++;
            if (q[0] != 258 || q[1] != 517) begin
                n_fail++;
                $display("FAIL held_start_pulse_cycles: got %0d,%0d want 258,517", q[0], q[1]);
            end
        end
        n_checks++;
        if (busy !== 1'b0 || product !== 256'd15) begin
            n_fail++;
            $display("FAIL held_start_result: busy=%b product=%h want 0 and 15", busy, product);
        end
        tick();
    endtask

    task automatic test_random();
        logic [255:0] ra;
        logic [255:0] rb;
        for (int i = 0; i < 250; i++) begin
            ra = rand256();
            rb = rand256();
            if ($urandom_range(0, 7) == 0) ra = P_REF + 256'($urandom_range(0, 1000));
            if ($urandom_range(0, 7) == 0) rb = P_REF - 256'($urandom_range(0, 1000));
            run_op(ra, rb, "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_inverse();
        test_unreduced();
        test_disturb();
        test_zero();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
